// File: rtl/idli_sqi_mem_m.sv
// ============================================================================
// Module      : idli_sqi_mem_m
// Description : SQI byte-memory responder (read 0x03 / write 0x02) with a
//               single-cycle backdoor write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idli_sqi_mem_m #(
  parameter int DEPTH = 65536
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst_n,
  input  logic        i_sqi_sck,
  input  logic        i_sqi_cs,
  input  logic [3:0]  i_sqi_sio,
  output logic [3:0]  o_sqi_sio,
  output logic        o_sqi_sio_oe,
  input  logic        i_sqi_bd_we,
  input  logic [15:0] i_sqi_bd_addr,
  input  logic [7:0]  i_sqi_bd_data,
  output logic        o_sqi_busy
);

  localparam int          c_AW   = $clog2(DEPTH);
  localparam logic [15:0] c_MASK = 16'(DEPTH - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_CMD    = 3'd1;
  localparam logic [2:0] c_ADDR   = 3'd2;
  localparam logic [2:0] c_DUMMY  = 3'd3;
  localparam logic [2:0] c_READ   = 3'd4;
  localparam logic [2:0] c_WRITE  = 3'd5;
  localparam logic [2:0] c_IGNORE = 3'd6;

  logic [7:0]  r_mem [DEPTH];

  logic [2:0]  r_state, w_state_nxt;
  logic        r_sck_q, r_cs_q;
  logic [2:0]  r_cnt, w_cnt_d;
  logic [3:0]  r_cmd_hi, w_cmd_hi_d;
  logic        r_is_read, w_is_read_d;
  logic [15:0] r_addr, w_addr_d;
  logic        r_half, w_half_d;
  logic [3:0]  r_wr_hi, w_wr_hi_d;
  logic [3:0]  r_sio, w_sio_d;
  logic        r_oe, w_oe_d;
  logic        w_mem_we;
  logic [7:0]  w_mem_wdata;

  logic        w_rise, w_fall, w_cs_fall;
  logic [7:0]  w_cmd;
  logic [15:0] w_addr_inc;
  logic [7:0]  w_mem_rd;

  assign w_rise     = i_sqi_sck & ~r_sck_q & ~i_sqi_cs;
  assign w_fall     = ~i_sqi_sck & r_sck_q & ~i_sqi_cs;
  // r_cs_q resets low so a chip select already low at reset release is not an edge
  assign w_cs_fall  = r_cs_q & ~i_sqi_cs & ~i_sqi_sck;
  assign w_cmd      = {r_cmd_hi, i_sqi_sio};
  assign w_addr_inc = (r_addr + 16'd1) & c_MASK;
  assign w_mem_rd   = r_mem[r_addr[c_AW-1:0]];

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_sqi_cs) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  if (w_cs_fall) w_state_nxt = c_CMD;
        c_CMD: begin
          if (w_rise && r_cnt == 3'd1) begin
            if (w_cmd == 8'h03 || w_cmd == 8'h02) w_state_nxt = c_ADDR;
            else                                  w_state_nxt = c_IGNORE;
          end
        end
        c_ADDR: begin
          if (w_rise && r_cnt == 3'd3) w_state_nxt = r_is_read ? c_DUMMY : c_WRITE;
        end
        c_DUMMY: if (w_rise && r_cnt == 3'd1) w_state_nxt = c_READ;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_cnt_d     = r_cnt;
    w_cmd_hi_d  = r_cmd_hi;
    w_is_read_d = r_is_read;
    w_addr_d    = r_addr;
    w_half_d    = r_half;
    w_wr_hi_d   = r_wr_hi;
    w_sio_d     = r_sio;
    w_oe_d      = r_oe;
    w_mem_we    = 1'b0;
    w_mem_wdata = {r_wr_hi, i_sqi_sio};

    if (w_state_nxt != r_state) begin
      w_cnt_d  = 3'd0;
      w_half_d = 1'b0;
    end else if (w_rise) begin
      w_cnt_d = 3'(r_cnt + 3'd1);
    end

    case (r_state)
      c_CMD: begin
        if (w_rise) begin
          if (r_cnt == 3'd0) w_cmd_hi_d  = i_sqi_sio;
          else               w_is_read_d = (w_cmd == 8'h03);
        end
      end
      c_ADDR: if (w_rise) w_addr_d = {r_addr[11:0], i_sqi_sio};
      c_READ: begin
        if (w_fall) begin
          w_oe_d = 1'b1;
          if (!r_half) begin
            w_sio_d  = w_mem_rd[7:4];
            w_half_d = 1'b1;
          end else begin
            w_sio_d  = w_mem_rd[3:0];
            w_half_d = 1'b0;
            w_addr_d = w_addr_inc;
          end
        end
      end
      c_WRITE: begin
        if (w_rise) begin
          if (!r_half) begin
            w_wr_hi_d = i_sqi_sio;
            w_half_d  = 1'b1;
          end else begin
            w_mem_we  = 1'b1;
            w_half_d  = 1'b0;
            w_addr_d  = w_addr_inc;
          end
        end
      end
      default: ;
    endcase

    if (w_state_nxt != c_READ) begin
      w_sio_d = 4'h0;
      w_oe_d  = 1'b0;
    end
  end

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      r_sck_q   <= 1'b0;
      r_cs_q    <= 1'b0;
      r_cnt     <= 3'd0;
      r_cmd_hi  <= 4'h0;
      r_is_read <= 1'b0;
      r_addr    <= 16'h0000;
      r_half    <= 1'b0;
      r_wr_hi   <= 4'h0;
      r_sio     <= 4'h0;
      r_oe      <= 1'b0;
    end else begin
      r_sck_q   <= i_sqi_sck;
      r_cs_q    <= i_sqi_cs;
      r_cnt     <= w_cnt_d;
      r_cmd_hi  <= w_cmd_hi_d;
      r_is_read <= w_is_read_d;
      r_addr    <= w_addr_d;
      r_half    <= w_half_d;
      r_wr_hi   <= w_wr_hi_d;
      r_sio     <= w_sio_d;
      r_oe      <= w_oe_d;
    end
  end

  // Serial write is issued last so it overrides a same-address backdoor write
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_bd_we) r_mem[i_sqi_bd_addr[c_AW-1:0]] <= i_sqi_bd_data;
    if (w_mem_we)    r_mem[r_addr[c_AW-1:0]]        <= w_mem_wdata;
  end

  assign o_sqi_sio    = r_sio;
  assign o_sqi_sio_oe = r_oe;
  assign o_sqi_busy   = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_idli_sqi_mem_m.sv
// ============================================================================
// Module      : tb_idli_sqi_mem_m
// Description : Directed self-checking bench for idli_sqi_mem_m.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idli_sqi_mem_m;

  logic        clk = 1'b0;
  logic        rst_n, sck, cs0, cs1, bd_we;
  logic [3:0]  sio;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;
  logic [3:0]  sio_o0, sio_o1;
  logic        oe0, oe1, busy0, busy1;
  logic        use_small;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  idli_sqi_mem_m #(.DEPTH(65536)) u_dut (
    .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .i_sqi_sck(sck), .i_sqi_cs(cs0),
    .i_sqi_sio(sio), .o_sqi_sio(sio_o0), .o_sqi_sio_oe(oe0),
    .i_sqi_bd_we(bd_we), .i_sqi_bd_addr(bd_addr), .i_sqi_bd_data(bd_data),
    .o_sqi_busy(busy0)
  );

  idli_sqi_mem_m #(.DEPTH(256)) u_dut_small (
    .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .i_sqi_sck(sck), .i_sqi_cs(cs1),
    .i_sqi_sio(sio), .o_sqi_sio(sio_o1), .o_sqi_sio_oe(oe1),
    .i_sqi_bd_we(bd_we), .i_sqi_bd_addr(bd_addr), .i_sqi_bd_data(bd_data),
    .o_sqi_busy(busy1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [5:0] obs();
    if (use_small) return {busy1, oe1, sio_o1};
    else           return {busy0, oe0, sio_o0};
  endfunction

  task automatic set_cs(input logic v);
    if (use_small) cs1 = v;
    else           cs0 = v;
  endtask

  task automatic start();
    set_cs(1'b0);
    tick(3);
  endtask

  task automatic stop();
    set_cs(1'b1);
    tick(3);
  endtask

  task automatic pulse(input logic [3:0] n);
    sio = n;
    sck = 1'b1;
    tick(3);
    sck = 1'b0;
    tick(3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    pulse(b[7:4]);
    pulse(b[3:0]);
  endtask

  task automatic bd_wr(input logic [15:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    tick(1);
    bd_we   = 1'b0;
  endtask

  // After this returns, the first nibble is already on the bus
  task automatic rd_start(input logic [15:0] a);
    start();
    send_byte(8'h03);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    pulse(4'h0);
    pulse(4'h0);
  endtask

  task automatic rd_nib(input string tag, input logic [3:0] exp);
    check(tag, {10'h0, obs()}, {10'h0, 2'b11, exp});
    pulse(4'h0);
  endtask

  task automatic wr_bytes(input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1);
    start();
    send_byte(8'h02);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(b0);
    send_byte(b1);
    stop();
  endtask

  initial begin
    rst_n = 1'b0; sck = 1'b0; cs0 = 1'b1; cs1 = 1'b1; sio = 4'h0;
    bd_we = 1'b0; bd_addr = 16'h0; bd_data = 8'h0; use_small = 1'b0;
    tick(3);
    check("rst_busy_oe_sio", {10'h0, obs()}, 16'h0000);
    rst_n = 1'b1;
    tick(3);

    // backdoor preload then serial read
    bd_wr(16'h0010, 8'hA5);
    bd_wr(16'h0011, 8'h3C);
    rd_start(16'h0010);
    rd_nib("rd10_n0", 4'hA);
    rd_nib("rd10_n1", 4'h5);
    rd_nib("rd10_n2", 4'h3);
    rd_nib("rd10_n3", 4'hC);
    stop();
    check("rd10_after_cs", {10'h0, obs()}, 16'h0000);

    // serial write then read back
    wr_bytes(16'h0100, 8'h12, 8'h34);
    rd_start(16'h0100);
    rd_nib("wr100_n0", 4'h1);
    rd_nib("wr100_n1", 4'h2);
    rd_nib("wr100_n2", 4'h3);
    rd_nib("wr100_n3", 4'h4);
    stop();

    // DEPTH=256 address wrap on write and read
    use_small = 1'b1;
    wr_bytes(16'h00FF, 8'hFF, 8'h77);
    rd_start(16'h0000);
    rd_nib("wrap_rd0_n0", 4'h7);
    rd_nib("wrap_rd0_n1", 4'h7);
    stop();
    rd_start(16'h00FF);
    rd_nib("wrap_rdff_n0", 4'hF);
    rd_nib("wrap_rdff_n1", 4'hF);
    rd_nib("wrap_rdff_n2", 4'h7);
    rd_nib("wrap_rdff_n3", 4'h7);
    stop();
    use_small = 1'b0;

    // unknown command: pattern that would write 0x55 to 0x0010 if decoded as write
    start();
    send_byte(8'h9F);
    begin
      logic [3:0] pat [8];
      pat = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h5, 4'h5, 4'h5, 4'h5};
      for (int i = 0; i < 8; i++) begin
        pulse(pat[i]);
        check($sformatf("ign_%0d", i), {10'h0, obs()}, 16'h0020);
      end
    end
    stop();
    check("ign_busy_drop", {15'h0, busy0}, 16'h0000);
    rd_start(16'h0010);
    rd_nib("ign_keep_n0", 4'hA);
    rd_nib("ign_keep_n1", 4'h5);
    stop();

    // partial write byte discarded on cs high
    bd_wr(16'h0020, 8'h5A);
    start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h20);
    pulse(4'h6);
    stop();
    rd_start(16'h0020);
    rd_nib("partial_n0", 4'h5);
    rd_nib("partial_n1", 4'hA);
    stop();

    // reset in the middle of a read
    rd_start(16'h0100);
    check("mid_rst_pre", {10'h0, obs()}, 16'h0031);
    rst_n = 1'b0;
    #1;
    check("mid_rst_now", {10'h0, obs()}, 16'h0000);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    pulse(4'h0);
    check("no_start_cs_low", {15'h0, busy0}, 16'h0000);
    stop();
    rd_start(16'h0100);
    rd_nib("post_rst_n0", 4'h1);
    rd_nib("post_rst_n1", 4'h2);
    rd_nib("post_rst_n2", 4'h3);
    rd_nib("post_rst_n3", 4'h4);
    stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/idli_sqi_mem_m.md
IDLI_SQI_MEM_M -- requirements
Module: idli_sqi_mem_m

Interface
REQ-001 SHALL have parameter DEPTH, default 65536, memory size in bytes (power of two, <= 65536).
REQ-002 SHALL have port i_sqi_gck  in  1  clock; the block's one clock, all state on rising edge.
REQ-003 SHALL have port i_sqi_rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port i_sqi_sck  in  1  serial clock from core, synchronous to i_sqi_gck.
REQ-005 SHALL have port i_sqi_cs  in  1  chip select, active-low.
REQ-006 SHALL have port i_sqi_sio  in  4  nibble driven by core (slice_t).
REQ-007 SHALL have port o_sqi_sio  out  4  nibble driven to core (slice_t).
REQ-008 SHALL have port o_sqi_sio_oe  out  1  high while responder drives o_sqi_sio.
REQ-009 SHALL have ports i_sqi_bd_we in 1, i_sqi_bd_addr in 16, i_sqi_bd_data in 8: backdoor byte write.
REQ-010 SHALL have port o_sqi_busy  out  1  high while a transaction is open (state != IDLE).

Function
REQ-011 SHALL register i_sqi_sck into sck_q; rise = sck & !sck_q, fall = !sck & sck_q, both qualified by cs low.
REQ-012 SHALL sample i_sqi_sio only in gck cycles where rise is set; state updates at the following gck edge.
REQ-013 SHALL require each sck phase >= 2 gck cycles; shorter phases are unsupported.
REQ-014 SHALL implement states IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE.
REQ-015 IDLE -> CMD when cs goes low; nibble counter cleared.
REQ-016 CMD: two nibbles, high first; 0x03 -> ADDR(read), 0x02 -> ADDR(write), any other -> IGNORE.
REQ-017 ADDR: four nibbles, high first, into 16-bit address; low log2(DEPTH) bits used; then DUMMY (read) or WRITE (write).
REQ-018 DUMMY: two rise nibbles ignored; o_sqi_sio_oe asserts on the fall after the second dummy nibble, o_sqi_sio = high nibble of mem[addr].
REQ-019 READ: on each fall, o_sqi_sio advances to the next nibble (high then low of each byte); after a low nibble, address increments.
REQ-020 WRITE: nibbles assembled high-first; on each second rise, byte written to mem[addr] and address increments.
REQ-021 Address increment SHALL wrap modulo DEPTH (DEPTH-1 -> 0) in both READ and WRITE.
REQ-022 IGNORE: all sck activity ignored, o_sqi_sio_oe low, until cs high.
REQ-023 cs high in any state SHALL force IDLE at next gck edge, drop o_sqi_sio_oe, discard any partial write byte.
REQ-024 o_sqi_sio and o_sqi_sio_oe SHALL be registered; update one gck after the detected fall/cs event.
REQ-025 o_sqi_sio SHALL be 4'h0 whenever o_sqi_sio_oe is low.
REQ-026 Backdoor write SHALL complete in one gck cycle; if coincident with a serial write to the same address, the serial write wins.
REQ-027 Memory contents SHALL not be reset; uninitialised bytes are X in simulation.

Reset
REQ-028 On i_sqi_rst_n low: state IDLE, sck_q 0, counters 0, address 0, o_sqi_sio 4'h0, o_sqi_sio_oe 0, o_sqi_busy 0.
REQ-029 Reset asserted mid-transaction SHALL abort it immediately; no partial byte written; memory retained.
REQ-030 After reset release, a transaction SHALL start only on a cs high-to-low seen after reset with sck low.

Verification
REQ-031 Backdoor mem[0x0010]=0xA5,0x3C; read cmd 0x03 addr 0x0010, 2 dummies, 4 falls -> o_sqi_sio A,5,3,C with oe high.
REQ-032 Write cmd 0x02 addr 0x0100 nibbles 1,2,3,4 then read 0x0100 -> 0x12,0x34 returned.
REQ-033 DEPTH=256: write 0xFF,0x77 starting at 0x00FF; read 0x0000 -> 0x77 (wrap).
REQ-034 Cmd 0x9F then 8 sck cycles -> oe stays low, memory unchanged, busy high until cs high then low.
REQ-035 Write addr 0x0020 nibble 6 only, cs high -> mem[0x0020] unchanged; new read transaction starts cleanly.
REQ-036 Assert rst_n low during READ -> oe 0, sio 4'h0, busy 0 immediately; memory contents preserved on re-read.
